// File: rtl/dma_copy_engine.sv
// dma_copy_engine: single-channel memory-to-memory word copier.
// Reads one 32-bit word from the source address, writes it to the destination
// address, and repeats for the requested word count. Only one bus transaction
// is in flight at any time. All outputs come straight from registers.
module dma_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             data_req,
    output logic             data_we,
    output logic [3:0]       data_be,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_gnt,
    input  logic             data_rvalid,
    input  logic [31:0]      data_rdata,
    input  logic             data_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_src, w_src_nxt;
    logic [31:0]      r_dst, w_dst_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_wdata, w_wdata_nxt;
    logic [31:0]      r_addr, w_addr_nxt;
    logic [3:0]       r_be, w_be_nxt;
    logic             r_req, w_req_nxt;
    logic             r_we, w_we_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic [31:0]      w_src_inc;
    logic [31:0]      w_dst_inc;
    logic [LEN_W-1:0] w_cnt_dec;

    assign w_src_inc = r_src + 32'd4;
    assign w_dst_inc = r_dst + 32'd4;
    assign w_cnt_dec = r_cnt - LEN_W'(1);

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign data_req   = r_req;
    assign data_we    = r_we;
    assign data_be    = r_be;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so that the bus signals leave the block from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        w_wdata_nxt = r_wdata;
        w_addr_nxt  = r_addr;
        w_be_nxt    = r_be;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_err_nxt = 1'b0;
                    if (len != '0) begin
                        w_src_nxt   = {src_addr[31:2], 2'b00};
                        w_dst_nxt   = {dst_addr[31:2], 2'b00};
                        w_cnt_nxt   = len;
                        w_busy_nxt  = 1'b1;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_be_nxt    = '1;
                        w_addr_nxt  = {src_addr[31:2], 2'b00};
                        w_state_nxt = RD_REQ;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (data_gnt) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (data_rvalid) begin
                    if (data_err) begin
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_wdata_nxt = data_rdata;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_be_nxt    = '1;
                        w_addr_nxt  = r_dst;
                        w_state_nxt = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (data_gnt) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (data_rvalid) begin
                    if (data_err) begin
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_we_nxt    = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_src_nxt = w_src_inc;
                        w_dst_nxt = w_dst_inc;
                        w_cnt_nxt = w_cnt_dec;
                        w_we_nxt  = 1'b0;
                        if (w_cnt_dec == '0) begin
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_req_nxt   = 1'b1;
                            w_be_nxt    = '1;
                            w_addr_nxt  = w_src_inc;
                            w_state_nxt = RD_REQ;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wdata <= w_wdata_nxt;
            r_addr  <= w_addr_nxt;
            r_be    <= w_be_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001: The block SHALL have parameter LEN_W, default 16, giving the width of the word-count input.
REQ-002: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003: The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004: The block SHALL have port start, input, 1 bit: a one-cycle request to begin a copy.
REQ-005: The block SHALL have port src_addr, input, 32 bits: source byte address.
REQ-006: The block SHALL have port dst_addr, input, 32 bits: destination byte address.
REQ-007: The block SHALL have port len, input, LEN_W bits: number of 32-bit words to copy.
REQ-008: The block SHALL have port busy, output, 1 bit: a copy is in progress.
REQ-009: The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010: The block SHALL have port err, output, 1 bit: sticky bus-error flag.
REQ-011: The block SHALL have ports data_req (output, 1), data_we (output, 1), data_be (output, 4), data_addr (output, 32) and data_wdata (output, 32): initiator side of the data bus.
REQ-012: The block SHALL have ports data_gnt (input, 1), data_rvalid (input, 1), data_rdata (input, 32) and data_err (input, 1): responder-driven side of the data bus.

Function
REQ-013: All outputs SHALL be registered.
REQ-014: The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, WR_REQ and WR_WAIT; at most one bus transaction is outstanding.
REQ-015: In IDLE, when start=1 and len!=0, the block SHALL latch src/dst with bits [1:0] forced to 0, latch len as the remaining count, set busy=1, clear err, and enter RD_REQ.
REQ-016: In IDLE, when start=1 and len=0, the block SHALL pulse done=1 for exactly one cycle, clear err, produce no bus traffic, and keep busy=0.
REQ-017: A start asserted while busy=1 SHALL be ignored.
REQ-018: In RD_REQ the block SHALL drive data_req=1, data_we=0 and data_addr=current source address, held stable until data_gnt is sampled high; then it SHALL enter RD_WAIT with data_req=0 in the following cycle.
REQ-019: In RD_WAIT, when data_rvalid=1 and data_err=0, the block SHALL capture data_rdata into the write-data register and enter WR_REQ.
REQ-020: In WR_REQ the block SHALL drive data_req=1, data_we=1, data_be=4'b1111, data_addr=current destination address and data_wdata=captured word, all stable until data_gnt is sampled high; then it SHALL enter WR_WAIT with data_req=0.
REQ-021: In WR_WAIT, on data_rvalid=1 with data_err=0, the block SHALL add 4 to both addresses (modulo 2^32, wrapping silently from 0xFFFFFFFC to 0) and decrement the remaining count.
REQ-022: After the update in REQ-021, the block SHALL return to RD_REQ if the remaining count is non-zero; otherwise it SHALL enter IDLE with busy=0 and done=1 for one cycle.
REQ-023: If data_rvalid=1 with data_err=1 is sampled in RD_WAIT or WR_WAIT, the block SHALL set err=1, pulse done, clear busy, enter IDLE, and not perform the pending write.
REQ-024: data_rvalid and data_err SHALL be ignored in IDLE, RD_REQ and WR_REQ.
REQ-025: data_be SHALL be 4'b1111 for both reads and writes.
REQ-026: Against a responder that grants 1 cycle after req and returns rvalid 1 cycle after gnt, each word SHALL take exactly 6 cycles, and done SHALL assert in the cycle following rising edge 6N after the edge that sampled start.
REQ-027: err SHALL remain set until the next accepted start.

Reset
REQ-028: While rst=0, the block SHALL be in IDLE with busy=0, done=0, err=0, data_req=0, data_we=0, data_be=0, data_addr=0, data_wdata=0 and internal counters at 0.
REQ-029: Assertion of rst in mid-transfer SHALL immediately abandon the transfer with no completion pulse.
REQ-030: After release of rst, no bus request SHALL be issued until a new start.

Verification
REQ-031: Copy test: start with src=0x100, dst=0x200, len=3 against the 1-cycle-gnt/1-cycle-rvalid responder -> reads of 0x100/0x104/0x108 and writes of 0x200/0x204/0x208 carry the read data; done in cycle 18; err=0.
REQ-032: Zero-length test: len=0 -> done pulses 1 cycle after start, data_req never asserts, busy stays 0.
REQ-033: Stalled-grant test: gnt delayed 5 cycles -> data_req, data_addr and data_wdata stay stable for all stall cycles, and exactly one transaction is counted per gnt.
REQ-034: Error test: data_err=1 on the rvalid of the second read with len=4 -> exactly one write occurs, then err=1, done pulses, busy=0; a following start clears err.
REQ-035: Wrap and ignore test: src=0xFFFFFFFC with len=2 -> the second read address is 0x00000000; a start issued while busy has no effect.
REQ-036: Reset test: rst=0 asserted during WR_REQ -> all outputs go to 0 asynchronously, and there is no done pulse after release.
